freq_cv_conditioner: RTL

Conditions the raw pitch control word from the ADC SPI receiver into the `frequency` value that drives the additive harmonic sample engine. It edge-detects the receiver's `data_received` strobe, runs a power-of-two moving average, clamps the result to the legal audio range and applies hysteresis to suppress jitter. The result is published only on the sample-boundary tick, so every harmonic of one output sample uses the same frequency.

---
 rtl/freq_cv_conditioner_pkg.sv | 22 ++
 rtl/freq_cv_conditioner_ring_average.sv | 57 +++++
 rtl/freq_cv_conditioner.sv | 110 +++++++++++
 3 files changed

// File: rtl/freq_cv_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_cv_conditioner_pkg
// Description : Shared constants and FSM encoding for the pitch CV conditioner
// Revision    : 1.0
// ============================================================================
package freq_cv_conditioner_pkg;

    localparam logic [15:0] FREQ_RESET = 16'd1000;
    localparam logic [15:0] FREQ_MIN   = 16'd20;
    localparam logic [15:0] FREQ_MAX   = 16'd12000;
    localparam int          SAMPLERATE = 48000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SUM   = 2'd1,
        S_CLAMP = 2'd2,
        S_HYST  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/freq_cv_conditioner_ring_average.sv
`default_nettype none
// ============================================================================
// Module      : cv_ring_average
// Description : Power-of-two moving average over a ring buffer with priming
// Revision    : 1.0
// ============================================================================
module cv_ring_average #(
    parameter int AVG_LOG2 = 3
) (
    input  logic        clock,
    input  logic        rstn,
    input  logic        load,
    input  logic [15:0] din,
    output logic [15:0] avg
);
    localparam int DEPTH = 1 << AVG_LOG2;

    logic [15:0]           r_buf [DEPTH];
    logic [AVG_LOG2-1:0]   r_wr_ptr;
    logic [15+AVG_LOG2:0]  r_sum;
    logic                  r_primed;

    always_ff @(posedge clock) begin
        if (!rstn) begin
            r_sum    <= '0;
            r_wr_ptr <= '0;
            r_primed <= 1'b0;
        end else if (load) begin
            if (!r_primed) begin
                // First word fills every slot so the average starts settled
                r_sum    <= {din, {AVG_LOG2{1'b0}}};
                r_primed <= 1'b1;
            end else begin
                r_sum    <= r_sum - {{AVG_LOG2{1'b0}}, r_buf[r_wr_ptr]}
                                  + {{AVG_LOG2{1'b0}}, din};
                r_wr_ptr <= r_wr_ptr + AVG_LOG2'(1);
            end
        end
    end

    // Buffer contents need no reset: priming overwrites all of them
    always_ff @(posedge clock) begin
        if (load) begin
            if (!r_primed) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_buf[i] <= din;
                end
            end else begin
                r_buf[r_wr_ptr] <= din;
            end
        end
    end

    assign avg = r_sum[15+AVG_LOG2:AVG_LOG2];

endmodule
`default_nettype wire

// File: rtl/freq_cv_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : freq_cv_conditioner
// Description : ADC pitch word -> averaged, clamped, hysteretic frequency
// Revision    : 1.0
// ============================================================================
module freq_cv_conditioner #(
    parameter int          AVG_LOG2   = 3,
    parameter logic [15:0] HYST       = 16'd4,
    parameter logic [15:0] FREQ_MIN   = freq_cv_conditioner_pkg::FREQ_MIN,
    parameter logic [15:0] FREQ_MAX   = freq_cv_conditioner_pkg::FREQ_MAX,
    parameter logic [15:0] FREQ_RESET = freq_cv_conditioner_pkg::FREQ_RESET
) (
    input  logic        clock,
    input  logic        rstn,
    input  logic        data_received,
    input  logic [15:0] adc_data,
    input  logic        sample_tick,
    output logic [15:0] frequency,
    output logic        freq_changed,
    output logic        sample_miss
);
    import freq_cv_conditioner_pkg::*;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_data_prev;
    logic [15:0] r_new_w;
    logic [15:0] r_clamped;
    logic [15:0] r_pending;
    logic [15:0] r_frequency;
    logic        r_freq_changed;
    logic        r_sample_miss;

    logic        w_rise;
    logic [15:0] w_avg;
    logic [15:0] w_clamp;
    logic [15:0] w_abs_diff;

    assign w_rise = data_received & ~r_data_prev;

    cv_ring_average #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_ring_average (
        .clock (clock),
        .rstn  (rstn),
        .load  (r_state == S_SUM),
        .din   (r_new_w),
        .avg   (w_avg)
    );

    assign w_clamp    = (w_avg < FREQ_MIN) ? FREQ_MIN :
                        (w_avg > FREQ_MAX) ? FREQ_MAX : w_avg;
    assign w_abs_diff = (r_clamped >= r_pending) ? (r_clamped - r_pending)
                                                 : (r_pending - r_clamped);

    always_ff @(posedge clock) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_rise) w_next_state = S_SUM;
            S_SUM:   w_next_state = S_CLAMP;
            S_CLAMP: w_next_state = S_HYST;
            S_HYST:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rstn) begin
            r_data_prev    <= 1'b0;
            r_new_w        <= '0;
            r_clamped      <= '0;
            r_pending      <= FREQ_RESET;
            r_frequency    <= FREQ_RESET;
            r_freq_changed <= 1'b0;
            r_sample_miss  <= 1'b0;
        end else begin
            r_data_prev   <= data_received;
            r_sample_miss <= w_rise && (r_state != S_IDLE);
            if ((r_state == S_IDLE) && w_rise) begin
                r_new_w <= adc_data;
            end
            if (r_state == S_CLAMP) begin
                r_clamped <= w_clamp;
            end
            if ((r_state == S_HYST) && (w_abs_diff >= HYST)) begin
                r_pending <= r_clamped;
            end
            // A tick coinciding with a pending write publishes the old value
            r_freq_changed <= sample_tick && (r_pending != r_frequency);
            if (sample_tick) begin
                r_frequency <= r_pending;
            end
        end
    end

    assign frequency    = r_frequency;
    assign freq_changed = r_freq_changed;
    assign sample_miss  = r_sample_miss;

endmodule
`default_nettype wire
